// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud generator with oversample, mid-bit and bit strobes.
// Divisor loads are staged and applied on a period boundary.
module uart_baud_gen #(
  parameter int CLK_HZ     = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int DEF_INT    = 325,
  parameter int DEF_FRAC   = 133
) (
  input  logic              clk50m,
  input  logic              reset,
  input  logic              enable,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic              clk_uart,
  output logic              div_pend,
  output logic              div_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W:0] CNT1 = 1;
  localparam logic [OS_W-1:0] OS1 = 1;
  localparam logic [OS_W-1:0] OS_MID = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_END = OS_W'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0
      || CLK_HZ <= 0) begin : g_bad_param
    $error("uart_baud_gen: bad OVERSAMPLE or CLK_HZ");
  end

  logic [DIV_W:0]    cnt;
  logic [DIV_W-1:0]  div_i;
  logic [DIV_W-1:0]  pend_i;
  logic [FRAC_W-1:0] div_f;
  logic [FRAC_W-1:0] pend_f;
  logic [FRAC_W-1:0] acc;
  logic [OS_W-1:0]   os_cnt;
  logic              pend;
  logic              err_q;
  logic              clk_q;

  logic [FRAC_W:0] acc_sum;
  logic [DIV_W:0]  len;
  logic            load_ok;
  logic            apply;

  // cnt runs 1..len within a period; 0 only while idle
  assign acc_sum = {1'b0, acc} + {1'b0, div_f};
  assign len     = {1'b0, div_i} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
  assign tick_os = (cnt == len);
  assign load_ok = div_load && (div_int >= DIV_W'(2));
  assign apply   = pend && (!enable || resync || tick_os);

  assign tick_mid = tick_os && (os_cnt == OS_MID);
  assign tick_bit = tick_os && (os_cnt == OS_END);
  assign clk_uart = clk_q;
  assign div_pend = pend;
  assign div_err  = err_q;

  always_ff @(posedge clk50m or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      os_cnt <= '0;
      clk_q  <= 1'b0;
      err_q  <= 1'b0;
      pend   <= 1'b0;
      pend_i <= '0;
      pend_f <= '0;
      div_i  <= DIV_W'(DEF_INT);
      div_f  <= FRAC_W'(DEF_FRAC);
    end else begin
      err_q <= div_load && !load_ok;

      if (!enable) begin
        cnt    <= '0;
        acc    <= '0;
        os_cnt <= '0;
        clk_q  <= 1'b0;
      end else if (resync) begin
        cnt    <= CNT1;
        acc    <= '0;
        os_cnt <= '0;
      end else if (tick_os) begin
        cnt    <= CNT1;
        acc    <= pend ? '0 : acc_sum[FRAC_W-1:0];
        os_cnt <= os_cnt + OS1;
        clk_q  <= ~clk_q;
      end else begin
        cnt <= cnt + CNT1;
      end

      if (apply) begin
        div_i <= pend_i;
        div_f <= pend_f;
        pend  <= 1'b0;
      end

      // a load in the apply cycle stays pending (last wins)
      if (load_ok) begin
        pend_i <= div_int;
        pend_f <= div_frac;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: divisor table plus load,
// error, resync and reset sequences.
module tb_uart_baud_gen;

  logic        clk50m = 1'b0;
  logic        reset;
  logic        enable;
  logic        div_load;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic        resync;
  logic        tick_os;
  logic        tick_mid;
  logic        tick_bit;
  logic        clk_uart;
  logic        div_pend;
  logic        div_err;

  uart_baud_gen dut (
    .clk50m   (clk50m),
    .reset    (reset),
    .enable   (enable),
    .div_load (div_load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .resync   (resync),
    .tick_os  (tick_os),
    .tick_mid (tick_mid),
    .tick_bit (tick_bit),
    .clk_uart (clk_uart),
    .div_pend (div_pend),
    .div_err  (div_err)
  );

  always #5 clk50m = ~clk50m;

  typedef struct {
    int i;
    int f;
    int n;
    int first;
    int total;
  } vec_t;

  vec_t vecs[7];

  int passed = 0;
  int total  = 0;

  int t_first, t_last, t_mid, t_bit1, t_bit2;
  int pend_n, err_n, tog;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic watch(input int n, input int ld_at, input int ld_i);
    int   c;
    int   k;
    logic prev;
    c = 0;
    k = 0;
    prev = clk_uart;
    t_first = -1;
    t_last = -1;
    t_mid = -1;
    t_bit1 = -1;
    t_bit2 = -1;
    pend_n = 0;
    err_n = 0;
    tog = 0;
    while (k < n && c < 20000) begin
      @(negedge clk50m);
      div_load = 1'b0;
      resync = 1'b0;
      c++;
      if (tick_os) begin
        k++;
        if (k == 1) t_first = c;
        t_last = c;
      end
      if (tick_mid && t_mid < 0) t_mid = c;
      if (tick_bit) begin
        if (t_bit1 < 0) t_bit1 = c;
        else if (t_bit2 < 0) t_bit2 = c;
      end
      if (div_pend) pend_n++;
      if (div_err) err_n++;
      if (clk_uart != prev) tog++;
      prev = clk_uart;
      if (c == ld_at) begin
        div_load = 1'b1;
        div_int = 16'(ld_i);
        div_frac = 8'd0;
      end
    end
    if (k < n) chk("watch_timeout_ticks", k, n);
  endtask

  task automatic load_idle(input int i, input int f);
    enable = 1'b0;
    @(negedge clk50m);
    div_load = 1'b1;
    div_int = 16'(i);
    div_frac = 8'(f);
    @(negedge clk50m);
    div_load = 1'b0;
    @(negedge clk50m);
    @(negedge clk50m);
  endtask

  function automatic int outs();
    return int'({tick_os, tick_mid, tick_bit,
                 clk_uart, div_pend, div_err});
  endfunction

  initial begin
    vecs[0] = '{4, 128, 16, 4, 72};
    vecs[1] = '{4, 0, 16, 4, 64};
    vecs[2] = '{6, 64, 4, 6, 25};
    vecs[3] = '{3, 255, 2, 3, 7};
    vecs[4] = '{2, 0, 8, 2, 16};
    vecs[5] = '{10, 0, 4, 10, 40};
    vecs[6] = '{5, 200, 3, 5, 17};

    reset = 1'b1;
    enable = 1'b1;
    div_load = 1'b0;
    div_int = '0;
    div_frac = '0;
    resync = 1'b0;

    repeat (3) @(negedge clk50m);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    watch(2, -1, 0);
    chk("post_reset_first_tick", t_first, 325);
    chk("post_reset_second_tick", t_last, 651);

    for (int v = 0; v < 7; v++) begin
      load_idle(vecs[v].i, vecs[v].f);
      enable = 1'b1;
      watch(vecs[v].n, -1, 0);
      chk($sformatf("vec%0d_first", v), t_first, vecs[v].first);
      chk($sformatf("vec%0d_total", v), t_last, vecs[v].total);
      chk($sformatf("vec%0d_toggles", v), tog, vecs[v].n - 1);
    end

    load_idle(325, 0);
    enable = 1'b1;
    watch(32, -1, 0);
    chk("i325_first_mid", t_mid, 2600);
    chk("i325_first_bit", t_bit1, 5200);
    chk("i325_bit_period", t_bit2 - t_bit1, 5200);
    chk("i325_mid_to_bit", t_bit1 - t_mid, 2600);

    load_idle(10, 0);
    enable = 1'b1;
    watch(3, 3, 6);
    chk("reload_pend_cycles", pend_n, 7);
    chk("reload_first_tick", t_first, 10);
    chk("reload_third_tick", t_last, 22);

    load_idle(6, 0);
    enable = 1'b1;
    watch(3, 2, 1);
    chk("bad_load_err_cycles", err_n, 1);
    chk("bad_load_pend_cycles", pend_n, 0);
    chk("bad_load_third_tick", t_last, 18);

    load_idle(4, 0);
    enable = 1'b1;
    watch(7, -1, 0);
    @(negedge clk50m);
    resync = 1'b1;
    watch(16, -1, 0);
    chk("resync_first_tick", t_first, 4);
    chk("resync_mid", t_mid, 32);
    chk("resync_bit", t_bit1, 64);

    load_idle(10, 0);
    enable = 1'b1;
    watch(1, -1, 0);
    @(negedge clk50m);
    @(negedge clk50m);
    div_load = 1'b1;
    div_int = 16'd6;
    div_frac = 8'd0;
    @(negedge clk50m);
    div_load = 1'b0;
    chk("pre_reset_pend", int'(div_pend), 1);
    #2 reset = 1'b1;
    #1 chk("mid_reset_outputs", outs(), 0);
    @(negedge clk50m);
    reset = 1'b0;
    watch(2, -1, 0);
    chk("rst_discard_first_tick", t_first, 325);
    chk("rst_discard_second_tick", t_last, 651);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
